// File: rtl/golden_nonce_detector.sv
// Golden-nonce detector: checks each completed double-SHA-256 result against
// the difficulty target, recovers the nonce that produced it, and queues hits
// in a small FIFO for the serial reporting logic (valid/ready handshake).
module golden_nonce_detector #(
   parameter logic [31:0] NONCE_OFFSET     = 32'd2,
   parameter int          TARGET_ZERO_BITS = 32,
   parameter int          FIFO_DEPTH       = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         hash_valid,
   input  logic [255:0] hash,
   input  logic [31:0]  nonce_in,
   output logic [31:0]  golden_nonce,
   output logic         golden_valid,
   input  logic         golden_ready,
   output logic         fifo_overflow,
   output logic [15:0]  match_count
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(FIFO_DEPTH);

   // Stage-1 registers: hit flag and recovered nonce for the hash just sampled
   logic              hit_q;
   logic [31:0]       nonce_q;

   // FIFO storage and bookkeeping
   logic [31:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  rd_ptr_inc;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_next;
   logic [31:0]       head_next;
   logic              fifo_full;
   logic              do_pop;
   logic              do_push;
   logic              do_drop;
   logic              target_met;

   // Only the top TARGET_ZERO_BITS of the hash matter; the rest is folded here
   // so the full bus is consumed.
   logic              unused_hash_parity;
   assign unused_hash_parity = ^hash;

   assign target_met = (hash[255 -: TARGET_ZERO_BITS] == '0);
   assign fifo_full  = (count == FULL_LEVEL);
   assign rd_ptr_inc = rd_ptr + 1'b1;

   // A pop frees a slot before the push is considered, so full+pop+push is legal
   assign do_pop  = (count != '0) && golden_ready;
   assign do_push = hit_q && (!fifo_full || do_pop);
   assign do_drop = hit_q && fifo_full && !do_pop;

   assign golden_valid = (count != '0);

   // Stage 1: register the target comparison and the nonce minus pipeline offset
   always_ff @(posedge clk) begin
      if (reset) begin
         hit_q   <= 1'b0;
         nonce_q <= '0;
      end else begin
         hit_q   <= hash_valid && target_met;
         nonce_q <= nonce_in - NONCE_OFFSET;
      end
   end

   // Occupancy after this edge, from the push/pop pair
   always_comb begin
      count_next = count;
      unique case ({do_push, do_pop})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   // Head register value after this edge; holds its last value when emptied
   always_comb begin
      head_next = golden_nonce;
      if (count_next != '0) begin
         if (do_pop) begin
            head_next = (count == CNT_W'(1)) ? nonce_q : mem[rd_ptr_inc];
         end else if (count == '0) begin
            head_next = nonce_q;
         end
      end
   end

   // FIFO storage writes (contents need no reset, occupancy guards them)
   always_ff @(posedge clk) begin
      if (!reset && do_push) begin
         mem[wr_ptr] <= nonce_q;
      end
   end

   // Stage 2: pointers, occupancy, head, overflow flag and hit counter
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         golden_nonce  <= '0;
         fifo_overflow <= 1'b0;
         match_count   <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr_inc;
         end
         count        <= count_next;
         golden_nonce <= head_next;
         if (do_drop) begin
            fifo_overflow <= 1'b1;
         end
         if (hit_q && (match_count != 16'hFFFF)) begin
            match_count <= match_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_golden_nonce_detector.sv
// Self-checking bench for golden_nonce_detector: directed scenarios with
// fixed expectations plus a randomized run against a queue-based model.
module tb_golden_nonce_detector;

   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         hash_valid;
   logic [255:0] hash;
   logic [31:0]  nonce_in;
   logic [31:0]  golden_nonce;
   logic         golden_valid;
   logic         golden_ready;
   logic         fifo_overflow;
   logic [15:0]  match_count;

   logic [31:0]  golden_nonce31;
   logic         golden_valid31;
   logic         ready31 = 1'b1;
   logic         fifo_overflow31;
   logic [15:0]  match_count31;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [31:0] mq[$];
   logic        m_ovf;
   logic [15:0] m_cnt;
   logic [31:0] m_head;
   logic        m_pend;
   logic [31:0] m_pend_nonce;

   always #5 clk = ~clk;

   golden_nonce_detector #(.NONCE_OFFSET(32'd2), .TARGET_ZERO_BITS(32), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .hash_valid(hash_valid), .hash(hash), .nonce_in(nonce_in),
      .golden_nonce(golden_nonce), .golden_valid(golden_valid), .golden_ready(golden_ready),
      .fifo_overflow(fifo_overflow), .match_count(match_count)
   );

   golden_nonce_detector #(.NONCE_OFFSET(32'd2), .TARGET_ZERO_BITS(31), .FIFO_DEPTH(DEPTH)) dut31 (
      .clk(clk), .reset(reset), .hash_valid(hash_valid), .hash(hash), .nonce_in(nonce_in),
      .golden_nonce(golden_nonce31), .golden_valid(golden_valid31), .golden_ready(ready31),
      .fifo_overflow(fifo_overflow31), .match_count(match_count31)
   );

   function automatic logic [255:0] rand_hash(input logic [31:0] top);
      return {top, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // Model of one clock edge: pop first, then the hit from the previous edge
   // is appended if there is room, then the current input is evaluated.
   task automatic model_edge();
      if (reset) begin
         mq.delete();
         m_ovf = 1'b0; m_cnt = 16'd0; m_head = 32'd0;
         m_pend = 1'b0; m_pend_nonce = 32'd0;
      end else begin
         if (mq.size() > 0 && golden_ready) void'(mq.pop_front());
         if (m_pend) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (mq.size() < DEPTH) mq.push_back(m_pend_nonce);
            else m_ovf = 1'b1;
         end
         if (mq.size() > 0) m_head = mq[0];
         m_pend       = hash_valid && (hash[255:224] == 32'd0);
         m_pend_nonce = nonce_in - 32'd2;
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, sample 1 time unit later
   task automatic cycle(input logic v, input logic [255:0] h, input logic [31:0] n, input logic r);
      hash_valid = v; hash = h; nonce_in = n; golden_ready = r;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle(1'b0, '0, 32'd0, 1'b0);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cycle(1'b0, '0, 32'd0, 1'b0);
      cycle(1'b0, '0, 32'd0, 1'b0);
      reset = 1'b0;
      cycle(1'b0, '0, 32'd0, 1'b0);
      checks++;
      if (golden_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", golden_valid); end
      checks++;
      if (golden_nonce !== 32'd0) begin failures++; $display("[TB] FAIL reset_nonce got=%h exp=0", golden_nonce); end
      checks++;
      if (fifo_overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf got=%b exp=0", fifo_overflow); end
      checks++;
      if (match_count !== 16'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", match_count); end
   endtask

   task automatic test_single_hit();
      do_reset();
      cycle(1'b1, rand_hash(32'd0), 32'h00000105, 1'b0);
      checks++;
      if (golden_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_latency got=%b exp=0", golden_valid); end
      cycle(1'b0, rand_hash($urandom), 32'd0, 1'b0);
      checks++;
      if (golden_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_valid got=%b exp=1", golden_valid); end
      checks++;
      if (golden_nonce !== 32'h00000103) begin failures++; $display("[TB] FAIL single_nonce got=%h exp=00000103", golden_nonce); end
      cycle(1'b0, '0, 32'd0, 1'b1);
      checks++;
      if (golden_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_pop got=%b exp=0", golden_valid); end
      checks++;
      if (match_count !== 16'd1) begin failures++; $display("[TB] FAIL single_count got=%0d exp=1", match_count); end
      checks++;
      if (golden_nonce !== 32'h00000103) begin failures++; $display("[TB] FAIL single_hold got=%h exp=00000103", golden_nonce); end
   endtask

   task automatic test_non_hit();
      do_reset();
      cycle(1'b1, rand_hash(32'h00000001), 32'h00000200, 1'b0);
      cycle(1'b0, '0, 32'd0, 1'b0);
      checks++;
      if (golden_valid !== 1'b0) begin failures++; $display("[TB] FAIL nonhit_valid got=%b exp=0", golden_valid); end
      checks++;
      if (match_count !== 16'd0) begin failures++; $display("[TB] FAIL nonhit_count got=%0d exp=0", match_count); end
      checks++;
      if (golden_valid31 !== 1'b1) begin failures++; $display("[TB] FAIL tz31_valid got=%b exp=1", golden_valid31); end
      checks++;
      if (golden_nonce31 !== 32'h000001FE) begin failures++; $display("[TB] FAIL tz31_nonce got=%h exp=000001fe", golden_nonce31); end
      checks++;
      if (match_count31 !== 16'd1) begin failures++; $display("[TB] FAIL tz31_count got=%0d exp=1", match_count31); end
   endtask

   task automatic test_wrap();
      do_reset();
      cycle(1'b1, rand_hash(32'd0), 32'h00000001, 1'b0);
      cycle(1'b0, '0, 32'd0, 1'b0);
      checks++;
      if (golden_nonce !== 32'hFFFFFFFF) begin failures++; $display("[TB] FAIL wrap_nonce got=%h exp=ffffffff", golden_nonce); end
      cycle(1'b1, rand_hash(32'd0), 32'h00000000, 1'b1);
      cycle(1'b0, '0, 32'd0, 1'b0);
      checks++;
      if (golden_nonce !== 32'hFFFFFFFE) begin failures++; $display("[TB] FAIL wrap_zero got=%h exp=fffffffe", golden_nonce); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 10; i <= 14; i++) cycle(1'b1, rand_hash(32'd0), 32'(i), 1'b0);
      cycle(1'b0, '0, 32'd0, 1'b0);
      checks++;
      if (fifo_overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag got=%b exp=1", fifo_overflow); end
      checks++;
      if (match_count !== 16'd5) begin failures++; $display("[TB] FAIL ovf_count got=%0d exp=5", match_count); end
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (golden_valid !== 1'b1 || golden_nonce !== 32'(8 + i)) begin
            failures++;
            $display("[TB] FAIL ovf_drain%0d got=%b/%h exp=1/%h", i, golden_valid, golden_nonce, 32'(8 + i));
         end
         cycle(1'b0, '0, 32'd0, 1'b1);
      end
      checks++;
      if (golden_valid !== 1'b0) begin failures++; $display("[TB] FAIL ovf_empty got=%b exp=0", golden_valid); end
      checks++;
      if (fifo_overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky got=%b exp=1", fifo_overflow); end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      for (int i = 20; i <= 23; i++) cycle(1'b1, rand_hash(32'd0), 32'(i), 1'b0);
      cycle(1'b1, rand_hash(32'd0), 32'd24, 1'b0);
      checks++;
      if (golden_nonce !== 32'd18) begin failures++; $display("[TB] FAIL full_head got=%h exp=00000012", golden_nonce); end
      cycle(1'b0, '0, 32'd0, 1'b1);
      checks++;
      if (fifo_overflow !== 1'b0) begin failures++; $display("[TB] FAIL full_ovf got=%b exp=0", fifo_overflow); end
      checks++;
      if (match_count !== 16'd5) begin failures++; $display("[TB] FAIL full_count got=%0d exp=5", match_count); end
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (golden_valid !== 1'b1 || golden_nonce !== 32'(19 + i)) begin
            failures++;
            $display("[TB] FAIL full_drain%0d got=%b/%h exp=1/%h", i, golden_valid, golden_nonce, 32'(19 + i));
         end
         cycle(1'b0, '0, 32'd0, 1'b1);
      end
      checks++;
      if (golden_valid !== 1'b0) begin failures++; $display("[TB] FAIL full_empty got=%b exp=0", golden_valid); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 30; i <= 33; i++) cycle(1'b1, rand_hash(32'd0), 32'(i), 1'b0);
      reset = 1'b1;
      cycle(1'b1, rand_hash(32'd0), 32'd34, 1'b0);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (golden_valid !== 1'b0 || golden_nonce !== 32'd0 || fifo_overflow !== 1'b0 || match_count !== 16'd0) begin
            failures++;
            $display("[TB] FAIL midreset%0d got=%b/%h/%b/%0d exp=0/0/0/0", k, golden_valid, golden_nonce, fifo_overflow, match_count);
         end
         cycle(1'b0, '0, 32'd0, 1'b1);
      end
   endtask

   task automatic test_random();
      logic [31:0] top;
      do_reset();
      for (int k = 0; k < 400; k++) begin
         case ($urandom_range(0, 3))
            0, 1:    top = 32'd0;
            2:       top = 32'd1;
            default: top = $urandom;
         endcase
         cycle($urandom_range(0, 3) != 0, rand_hash(top), $urandom, $urandom_range(0, 2) == 0);
         checks++;
         if (golden_valid !== (mq.size() > 0) || golden_nonce !== m_head ||
             fifo_overflow !== m_ovf || match_count !== m_cnt) begin
            failures++;
            $display("[TB] FAIL random%0d got=%b/%h/%b/%0d exp=%b/%h/%b/%0d", k,
                     golden_valid, golden_nonce, fifo_overflow, match_count,
                     mq.size() > 0, m_head, m_ovf, m_cnt);
         end
      end
   endtask

   initial begin
      reset = 1'b1; hash_valid = 1'b0; hash = '0; nonce_in = '0; golden_ready = 1'b0;
      test_reset();
      test_single_hit();
      test_non_hit();
      test_wrap();
      test_overflow();
      test_full_push_pop();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
